load_store_unit: RTL and testbench

Memory-stage load/store initiator for the pipelined MIPS core. It takes the MEM-stage access (read/write, size, signedness, byte address), issues one request/acknowledge transaction to a variable-latency word-wide data memory, and returns an aligned, extended load result. While the access is outstanding it stalls the pipeline. It is the requesting end of the data-memory port: byte-lane steering, byte enables and the handshake live here, not in the memory.

---
 rtl/lsu_pkg.sv | 16 +
 rtl/lsu_mem_if.sv | 24 ++
 rtl/lsu_lane_fmt.sv | 50 +++++
 rtl/load_store_unit.sv | 117 +++++++++++
 tb/tb_load_store_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Contents: access size codes and the FSM state encoding.
package lsu_pkg;

    // Access size codes; 2'b11 is decoded as a word everywhere.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_DONE = 2'b10
    } lsu_state_t;

endpackage

// File: rtl/lsu_mem_if.sv
// Data-memory request/acknowledge port.
// master (LSU side): drives m_req, m_we, m_addr, m_wdata, m_be; receives m_ack, m_rdata.
// slave  (memory side): the reverse.
interface lsu_mem_if #(
    parameter int ADDR_W = 32
);
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [3:0]        m_be;
    logic              m_ack;
    logic [31:0]       m_rdata;

    modport master (
        output m_req, m_we, m_addr, m_wdata, m_be,
        input  m_ack, m_rdata
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, m_be,
        output m_ack, m_rdata
    );
endinterface

// File: rtl/lsu_lane_fmt.sv
// Byte-lane formatting for the load/store unit (purely combinational).
// Inputs : size, load_unsigned, lo (adr[1:0]), write_data, rd_word (memory word).
// Outputs: wdata (lane-replicated store data), be (byte enables, bit k = lane k),
//          load_data (selected lanes, zero/sign extended).
module lsu_lane_fmt
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [1:0]  lo,
    input  logic [31:0] write_data,
    input  logic [31:0] rd_word,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lo)
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = lo[1] ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        wdata     = write_data;
        be        = 4'b1111;
        load_data = rd_word;
        case (size)
            SZ_BYTE: begin
                wdata     = {4{write_data[7:0]}};
                be        = 4'b0001 << lo;
                load_data = {{24{~load_unsigned & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                wdata     = {2{write_data[15:0]}};
                be        = lo[1] ? 4'b1100 : 4'b0011;
                load_data = {{16{~load_unsigned & half_sel[15]}}, half_sel};
            end
            default: ;  // word (10 and 11)
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator.
// Pipeline side: mem_read, mem_write, size, load_unsigned, adr, write_data in;
//                read_data, stall, misaligned out.
// Memory side  : lsu_mem_if.master (registered request outputs, m_ack/m_rdata in).
// clk rising edge; rst synchronous, active-low.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              load_unsigned,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              stall,
    output logic              misaligned,
    lsu_mem_if.master         mem
);

    lsu_state_t        state, state_nx;
    logic              req_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, word_q;
    logic [3:0]        be_q;
    logic [1:0]        size_q, lo_q;
    logic              uns_q;

    logic              any_req, bad_align, access;
    logic [1:0]        fmt_size, fmt_lo;
    logic              fmt_uns;
    logic [31:0]       fmt_wdata, fmt_load;
    logic [3:0]        fmt_be;

    assign any_req    = mem_read | mem_write;
    // size[1] set means word (10 or 11).
    assign bad_align  = ((size == SZ_HALF) & adr[0]) | (size[1] & (adr[1:0] != 2'b00));
    assign misaligned = any_req & bad_align;
    assign access     = any_req & ~bad_align;
    assign stall      = rst & access & (state != LSU_DONE);

    // One formatter serves both directions: in IDLE it steers the live store,
    // afterwards it extracts from the captured word using the captured fields.
    assign fmt_size = (state == LSU_IDLE) ? size          : size_q;
    assign fmt_lo   = (state == LSU_IDLE) ? adr[1:0]      : lo_q;
    assign fmt_uns  = (state == LSU_IDLE) ? load_unsigned : uns_q;

    lsu_lane_fmt u_fmt (
        .size          (fmt_size),
        .load_unsigned (fmt_uns),
        .lo            (fmt_lo),
        .write_data    (write_data),
        .rd_word       (word_q),
        .wdata         (fmt_wdata),
        .be            (fmt_be),
        .load_data     (fmt_load)
    );

    always_comb begin
        state_nx = state;
        case (state)
            LSU_IDLE: if (access) state_nx = LSU_REQ;
            LSU_REQ:  if (mem.m_ack) state_nx = LSU_DONE;
            LSU_DONE: state_nx = LSU_IDLE;
            default:  state_nx = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= LSU_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            word_q  <= '0;
            size_q  <= SZ_BYTE;
            lo_q    <= 2'b00;
            uns_q   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                LSU_IDLE: if (access) begin
                    req_q   <= 1'b1;
                    we_q    <= mem_write;
                    addr_q  <= {adr[ADDR_W-1:2], 2'b00};
                    wdata_q <= mem_write ? fmt_wdata : 32'h0;
                    be_q    <= fmt_be;
                    size_q  <= size;
                    lo_q    <= adr[1:0];
                    uns_q   <= load_unsigned;
                end
                LSU_REQ: if (mem.m_ack) begin
                    req_q <= 1'b0;
                    if (!we_q) word_q <= mem.m_rdata;
                end
                default: ;
            endcase
        end
    end

    assign mem.m_req   = req_q;
    assign mem.m_we    = we_q;
    assign mem.m_addr  = addr_q;
    assign mem.m_wdata = wdata_q;
    assign mem.m_be    = be_q;

    // Stores have no load result, so read_data stays 0 for them.
    assign read_data = ((state == LSU_DONE) && !we_q) ? fmt_load : '0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, load_unsigned;
    logic [1:0]  size;
    logic [31:0] adr, write_data, read_data;
    logic        stall, misaligned;

    int errors = 0;
    int checks = 0;

    lsu_mem_if #(.ADDR_W(32)) mif ();

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .size          (size),
        .load_unsigned (load_unsigned),
        .adr           (adr),
        .write_data    (write_data),
        .read_data     (read_data),
        .stall         (stall),
        .misaligned    (misaligned),
        .mem           (mif.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 4'(1 << a[1:0]);
        if (sz == 2'd1) return (a[1:0] >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return (wd & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input bit uns,
                                           input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * a[1:0])) & 32'hFF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * (a[1:0] / 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic clear_inputs();
        mem_read = 0; mem_write = 0; size = 0; load_unsigned = 0; adr = 0; write_data = 0;
    endtask

    // Entered and left just after a rising edge with the FSM in IDLE.
    task automatic do_access(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                             input logic [31:0] a, input logic [31:0] wd, input int lat,
                             input logic [31:0] rw, output int stalls);
        bit mis;
        int st;
        logic [31:0] exp_wd;
        mis = (rd | wr) && m_mis(sz, a);
        exp_wd = wr ? m_wdata(sz, wd) : 32'h0;
        mem_read = rd; mem_write = wr; size = sz; load_unsigned = uns; adr = a; write_data = wd;
        st = 0;
        @(negedge clk);
        check("misaligned", {31'b0, misaligned}, {31'b0, mis});
        check("stall_idle", {31'b0, stall}, {31'b0, !mis});
        if (stall) st++;
        if (mis) begin
            repeat (2) begin
                @(posedge clk); #1;
                @(negedge clk);
                check("mis_no_req", {31'b0, mif.m_req}, 32'h0);
                if (stall) st++;
            end
            clear_inputs();
            @(posedge clk); #1;
            stalls = st;
            return;
        end
        @(posedge clk); #1;
        for (int w = 0; w <= lat; w++) begin
            mif.m_ack   = (w == lat);
            mif.m_rdata = (w == lat) ? rw : $urandom;
            @(negedge clk);
            check("req_hi", {31'b0, mif.m_req}, 32'h1);
            check("we", {31'b0, mif.m_we}, {31'b0, wr});
            check("addr", mif.m_addr, {a[31:2], 2'b00});
            check("be", {28'b0, mif.m_be}, {28'b0, m_be(sz, a)});
            check("wdata", mif.m_wdata, exp_wd);
            if (stall) st++;
            @(posedge clk); #1;
        end
        mif.m_ack = 0;
        @(negedge clk);
        check("req_lo_done", {31'b0, mif.m_req}, 32'h0);
        check("stall_done", {31'b0, stall}, 32'h0);
        if (!wr) check("read_data", read_data, m_load(sz, uns, a, rw));
        clear_inputs();
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_rd0", read_data, 32'h0);
        @(posedge clk); #1;
        stalls = st;
    endtask

    initial begin
        int stl;
        logic [5:0] reqs;
        rst = 0;
        clear_inputs();
        mif.m_ack = 0; mif.m_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'b0, mif.m_req}, 32'h0);
        check("rst_addr", mif.m_addr, 32'h0);
        check("rst_be", {28'b0, mif.m_be}, 32'h0);
        check("rst_rd", read_data, 32'h0);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;

        // Word load, 2 wait cycles.
        do_access(1, 0, 2'd2, 0, 32'h2004, 0, 2, 32'hDEADBEEF, stl);
        check("word_stalls", stl, 4);
        // Signed / unsigned byte loads.
        do_access(1, 0, 2'd0, 0, 32'h2003, 0, 0, 32'h80112233, stl);
        check("sb_stalls", stl, 2);
        do_access(1, 0, 2'd0, 1, 32'h2003, 0, 1, 32'h80112233, stl);
        check("ub_stalls", stl, 3);
        // Half store, upper half.
        do_access(0, 1, 2'd1, 0, 32'h2006, 32'h0000ABCD, 2, 32'h0, stl);
        check("sh_stalls", stl, 4);
        // Misaligned word load.
        do_access(1, 0, 2'd2, 0, 32'h2002, 0, 0, 32'h0, stl);
        check("mis_stalls", stl, 0);

        // Reset while in REQ, late ack ignored.
        mem_read = 1; size = 2'd2; adr = 32'h3000;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("stall_in_rst", {31'b0, stall}, 32'h0);
        @(posedge clk); #1;
        rst = 1;
        clear_inputs();
        mif.m_ack = 1;
        mif.m_rdata = 32'h12345678;
        @(negedge clk);
        check("abort_req", {31'b0, mif.m_req}, 32'h0);
        check("abort_we", {31'b0, mif.m_we}, 32'h0);
        check("abort_addr", mif.m_addr, 32'h0);
        check("abort_wdata", mif.m_wdata, 32'h0);
        check("abort_be", {28'b0, mif.m_be}, 32'h0);
        @(posedge clk); #1;
        mif.m_ack = 0;
        @(negedge clk);
        check("late_ack_req", {31'b0, mif.m_req}, 32'h0);
        check("late_ack_rd", read_data, 32'h0);
        @(posedge clk); #1;

        // Back-to-back stores with immediate ack.
        reqs = 0;
        mem_write = 1; size = 2'd2; adr = 32'h2010; write_data = 32'h11112222;
        @(negedge clk); reqs = {reqs[4:0], mif.m_req};
        check("b2b_stall0", {31'b0, stall}, 32'h1);
        @(posedge clk); #1; mif.m_ack = 1;
        @(negedge clk); reqs = {reqs[4:0], mif.m_req};
        @(posedge clk); #1; mif.m_ack = 0;
        size = 2'd0; adr = 32'h2021; write_data = 32'h00000055;
        @(negedge clk); reqs = {reqs[4:0], mif.m_req};
        check("b2b_stall_done", {31'b0, stall}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk); reqs = {reqs[4:0], mif.m_req};
        check("b2b_stall_idle", {31'b0, stall}, 32'h1);
        @(posedge clk); #1; mif.m_ack = 1;
        @(negedge clk); reqs = {reqs[4:0], mif.m_req};
        check("b2b_addr", mif.m_addr, 32'h2020);
        check("b2b_be", {28'b0, mif.m_be}, 32'h2);
        check("b2b_wdata", mif.m_wdata, 32'h55555555);
        @(posedge clk); #1; mif.m_ack = 0;
        clear_inputs();
        @(negedge clk); reqs = {reqs[4:0], mif.m_req};
        check("b2b_pattern", {26'b0, reqs}, 32'b010010);
        @(posedge clk); #1;

        // Randomized accesses.
        for (int i = 0; i < 40; i++) begin
            bit rd, wr, uns, mis;
            logic [1:0] sz;
            logic [31:0] a, wd, rw;
            int lat;
            rd  = $urandom_range(0, 1);
            wr  = $urandom_range(0, 1);
            if (!rd && !wr) rd = 1;
            sz  = 2'($urandom_range(0, 3));
            uns = $urandom_range(0, 1);
            a   = 32'h1000 + ($urandom & 32'h0FFF);
            wd  = $urandom;
            rw  = $urandom;
            lat = $urandom_range(0, 3);
            mis = m_mis(sz, a);
            do_access(rd, wr, sz, uns, a, wd, lat, rw, stl);
            check("rnd_stalls", stl, mis ? 0 : lat + 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
